// File: rtl/booth_encode.sv
// booth_encode: radix-8 multiple-select encoder for the unsigned 8x8 multiplier.
// Turns one W-bit multiplier digit into a one-hot select of the precomputed
// multiple kX (bit k-1). A digit of 0 selects nothing (all-zero select).
// Default build registers the select: 1-cycle latency, asynchronous
// active-low reset to zero.
// Optional macro BOOTH_ENCODE_COMB_EN: removes the output register so the
// select follows iDat combinationally. clk and rst stay on the port list but
// are unused in that build.
module booth_encode #(
  parameter int ENCODE_DATA_WIDTH      = 3,
  parameter int ENCODE_OBOOTHSEL_WIDTH = 7
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ENCODE_DATA_WIDTH-1:0]      iDat,
  output logic [ENCODE_OBOOTHSEL_WIDTH-1:0] oBoothSel
);

  // The select must have exactly one bit per non-zero digit value.
  if (ENCODE_OBOOTHSEL_WIDTH != (1 << ENCODE_DATA_WIDTH) - 1) begin : g_width_check
    $error("booth_encode: ENCODE_OBOOTHSEL_WIDTH must equal 2**ENCODE_DATA_WIDTH - 1");
  end

  logic [ENCODE_OBOOTHSEL_WIDTH-1:0] sel_next;

  // Decode loop: select bit k-1 is set only when the digit equals k, so the
  // result is one-hot for k >= 1 and all-zero for a digit of 0.
  for (genvar gi = 1; gi <= ENCODE_OBOOTHSEL_WIDTH; gi++) begin : g_decode
    assign sel_next[gi-1] = (iDat == ENCODE_DATA_WIDTH'(gi));
  end

`ifdef BOOTH_ENCODE_COMB_EN
  // Clock and reset have no function in the combinational build.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  assign oBoothSel = sel_next;
`else
  logic [ENCODE_OBOOTHSEL_WIDTH-1:0] sel_reg;

  // Output register: captures the decoded select each edge; reset forces
  // the "select nothing" code and drops whatever was pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_reg <= '0;
    end else begin
      sel_reg <= sel_next;
    end
  end

  assign oBoothSel = sel_reg;
`endif

endmodule

// File: tb/tb_booth_encode.sv
// tb_booth_encode: scoreboard bench for booth_encode.
// The driver pushes the hand-computed expected select for every digit it
// applies; an independent monitor pops and compares one cycle later, and
// also checks that the select is never multi-hot.
`timescale 1ns/1ps
module tb_booth_encode;

  logic       clk;
  logic       rst;
  logic [2:0] iDat;
  logic [6:0] oBoothSel;

  int checks = 0;
  int errors = 0;

  // Hand-computed select for digits 0..7 (bit k-1 selects kX).
  logic [6:0] exp_tab [8];

  logic [6:0] exp_q [$];

  booth_encode #(
    .ENCODE_DATA_WIDTH     (3),
    .ENCODE_OBOOTHSEL_WIDTH(7)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .iDat     (iDat),
    .oBoothSel(oBoothSel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b at %0t", name, got, exp, $time);
    end else begin
      $display("chk %s got=%b exp=%b ok", name, got, exp);
    end
  endtask

`ifndef BOOTH_ENCODE_COMB_EN
  // Driver step: apply a digit shortly after an edge and queue its expected
  // select, which appears after the following edge.
  task automatic drive(input logic [2:0] d, input logic [6:0] e);
    @(posedge clk);
    #2;
    iDat = d;
    exp_q.push_back(e);
  endtask

  // Monitor: after every edge check one-hotness, then pop and compare if a
  // result is due.
  always @(posedge clk) begin
    logic [6:0] e;
    #1;
    checks++;
    if ($countones(oBoothSel) > 1) begin
      errors++;
      $display("FAIL onehot got=%b exp=at_most_one_bit at %0t", oBoothSel, $time);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("scoreboard", oBoothSel, e);
    end
  end
`endif

  initial begin
    exp_tab[0] = 7'b0000000;
    exp_tab[1] = 7'b0000001;
    exp_tab[2] = 7'b0000010;
    exp_tab[3] = 7'b0000100;
    exp_tab[4] = 7'b0001000;
    exp_tab[5] = 7'b0010000;
    exp_tab[6] = 7'b0100000;
    exp_tab[7] = 7'b1000000;

    rst  = 1'b0;
    iDat = 3'd5;

`ifdef BOOTH_ENCODE_COMB_EN
    // Combinational build: select follows iDat with no edge, reset ignored.
    #3;
    iDat = 3'd2;
    #1 check("comb_2", oBoothSel, 7'b0000010);
    iDat = 3'd7;
    #1 check("comb_7", oBoothSel, 7'b1000000);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      iDat = 3'(i);
      #1 check("comb_sweep", oBoothSel, exp_tab[i]);
    end
    rst = 1'b0;
    iDat = 3'd7;
    #1 check("comb_rst_ignored", oBoothSel, 7'b1000000);
`else
    // Reset held low with a non-zero digit: output stays zero.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("reset_hold", oBoothSel, 7'b0000000);
    end

    // Release between edges; the first edge captures encode(5).
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1 check("first_after_reset", oBoothSel, 7'b0010000);

    // Sweep 0..7 with an asynchronous reset pulse while 6 is pending.
    for (int i = 0; i < 8; i++) begin
      drive(3'(i), exp_tab[i]);
      if (i == 6) begin
        #2 rst = 1'b0;
        #1 check("async_reset", oBoothSel, 7'b0000000);
        #1 rst = 1'b1;
      end
    end

    // Wrap 7 -> 0 -> 1 on consecutive cycles.
    drive(3'd0, 7'b0000000);
    drive(3'd1, 7'b0000001);
    drive(3'd7, 7'b1000000);
    drive(3'd0, 7'b0000000);
    drive(3'd1, 7'b0000001);

    // Hold at 3 for ten cycles.
    for (int i = 0; i < 10; i++) begin
      drive(3'd3, 7'b0000100);
    end

    // Let the last result drain, then confirm nothing is left unchecked.
    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d exp=0 pending", exp_q.size());
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/booth_encode.md
Name:
booth_encode

Overview:
- Radix-8 multiple-select encoder for the unsigned 8x8 multiplier.
- Takes one 3-bit multiplier digit and produces a one-hot select: which precomputed multiple (1X..7X) of the multiplicand feeds the partial-product mux.
- Digit value 0 selects nothing (all-zero select).
- Sits between the multiplier-operand slicer and the partial-product generator; output is registered by default.

Parameters:
- ENCODE_DATA_WIDTH, 3, width W of the input digit.
- ENCODE_OBOOTHSEL_WIDTH, 7, width of the one-hot select. Must equal 2^W - 1; any other value is an elaboration error via a generate-time check.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-low.
- iDat  input  ENCODE_DATA_WIDTH  unsigned multiplier digit, value 0..2^W-1.
- oBoothSel  output  ENCODE_OBOOTHSEL_WIDTH  one-hot multiple select; bit k-1 selects multiple kX.

Behaviour:
- Encode function, for digit value d = iDat:
  - d = 0: select is all zeros.
  - d = k, 1 <= k <= 2^W-1: select has bit k-1 = 1 and all other bits 0.
- For W=3: 0->7'b0000000, 1->0000001, 2->0000010, 3->0000100, 4->0001000, 5->0010000, 6->0100000, 7->1000000.
- Output is one-hot or all-zero at all times, never multi-hot.
- Register stage (default build):
  - oBoothSel is a flop updated on every rising clk edge with encode(iDat).
  - Latency is 1 cycle; throughput is 1 digit per cycle; there is no enable or handshake.
- Reset:
  - rst low asynchronously forces oBoothSel to all zeros, the "select nothing" code, independent of clk.
  - While rst is held low the output stays zero.
  - The first rising edge after rst deasserts captures encode(iDat).
  - Reset asserted mid-stream drops the pending value; no state survives reset.
- Wrap-around: iDat stepping 7->0 produces 1000000 followed by 0000000 on consecutive cycles. No special handling is needed.
- X handling: if iDat contains X/Z, the output may be X. There is no X-masking.
- Implementation:
  - Encoder is a parameterised decode loop over k = 1..2^W-1, not a hard-coded case statement.
  - Select bit 0 corresponds to 1X.

Optional Feature:
- Macro BOOTH_ENCODE_COMB_EN.
- When defined:
  - The output register is removed and oBoothSel = encode(iDat) combinationally, with 0-cycle latency.
  - clk and rst remain on the port list but are unused.
  - Reset has no effect on the output.
- When undefined: registered behaviour as above, with 1-cycle latency and async-low reset to zero.

Test Plan:
- Reset: hold rst=0 with iDat=5 for several clocks -> oBoothSel=0000000 throughout. Asserting rst between clock edges forces 0000000 immediately.
- Sweep: after reset release, drive iDat 0,1,...,7 on consecutive cycles -> oBoothSel one cycle later is 0000000, 0000001, 0000010, 0000100, 0001000, 0010000, 0100000, 1000000.
- Wrap: free-running counter iDat 7->0->1 -> outputs 1000000, 0000000, 0000001 on consecutive cycles. At every cycle check $countones(oBoothSel) <= 1.
- Mid-stream reset: during the sweep at iDat=6, pulse rst low between edges -> output drops to 0000000 asynchronously. After release the next edge shows encode of the current iDat.
- Hold: iDat held at 3 for 10 cycles -> oBoothSel stays 0000100 with no glitch at edges.
- Combinational build (BOOTH_ENCODE_COMB_EN defined): change iDat 2->7 with no clock edge -> oBoothSel goes 0000010->1000000 within the same delta. rst=0 does not zero the output.
